// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux select sequencer.
// Beat order is set by MUX_SEQ_MSB_FIRST_EN (defined: in[3] first; undefined: in[0] first).
package mux_seq_pkg;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 2;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } seq_state_t;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] START_SEL = 2'd3;
  localparam logic [SEL_W-1:0] END_SEL   = 2'd0;
`else
  localparam logic [SEL_W-1:0] START_SEL = 2'd0;
  localparam logic [SEL_W-1:0] END_SEL   = 2'd3;
`endif

  // Moves the select one position toward END_SEL.
  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return sel - 1'b1;
`else
    return sel + 1'b1;
`endif
  endfunction

endpackage

// File: rtl/mux_seq_gap_cnt.sv
// Loadable down-counter that times the idle gap between words.
// o_done is high whenever the count sits at zero.
module mux_seq_gap_cnt
  import mux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [GAP_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [GAP_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Latches a 4-bit word and walks mux_sel through all four positions, one beat per bit_ready.
// Beat order selected by MUX_SEQ_MSB_FIRST_EN; GAP_CYCLES inserts idle cycles between words.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [DATA_W-1:0] word_in,
  input  logic              bit_ready,
  output logic [SEL_W-1:0]  mux_sel,
  output logic [DATA_W-1:0] mux_in,
  output logic              bit_valid,
  output logic              bit_first,
  output logic              bit_last,
  output logic              busy
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_word;
  logic              w_last;
  logic              w_load_word;
  logic              w_step;
  logic              w_gap_done;

  assign w_last = (r_state == SEND) && (r_sel == END_SEL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load_word = 1'b0;
    w_step      = 1'b0;
    word_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        word_ready = 1'b1;
        if (word_valid) begin
          w_load_word = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (bit_ready) begin
          if (!w_last) begin
            w_step = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
          end else begin
            // Zero-gap build: the last beat doubles as the accept slot for the next word.
            word_ready = 1'b1;
            if (word_valid) begin
              w_load_word = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (w_gap_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= START_SEL;
      r_word <= '0;
    end else if (w_load_word) begin
      r_word <= word_in;
      r_sel  <= START_SEL;
    end else if (w_step) begin
      r_sel  <= step_sel(r_sel);
    end
  end

  if (GAP_CYCLES > 0) begin : g_gap
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    logic w_gap_load;
    logic w_gap_dec;
    assign w_gap_load = (r_state == SEND) && (w_state_nxt == GAP);
    assign w_gap_dec  = (r_state == GAP);

    mux_seq_gap_cnt u_gap_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_gap_load),
      .i_load_val (GAP_LOAD),
      .i_dec      (w_gap_dec),
      .o_done     (w_gap_done)
    );
  end else begin : g_no_gap
    assign w_gap_done = 1'b1;
  end

  assign mux_sel   = r_sel;
  assign mux_in    = r_word;
  assign bit_valid = (r_state == SEND);
  assign bit_first = (r_state == SEND) && (r_sel == START_SEL);
  assign bit_last  = w_last;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: the sequencer drives a 4:1 mux modelled four ways; each beat is
// compared against the expected bit queued when its word was accepted.
module tb_mux_sel_sequencer;
  import mux_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       word_valid = 1'b0;
  logic       bit_ready = 1'b0;
  logic [3:0] word_in = 4'h0;
  logic       word_ready, bit_valid, bit_first, bit_last, busy;
  logic [1:0] mux_sel;
  logic [3:0] mux_in;

  logic       g_word_valid = 1'b0;
  logic [3:0] g_word_in = 4'h0;
  logic       g_bit_ready = 1'b1;
  logic       g_word_ready, g_bit_valid, g_bit_first, g_bit_last, g_busy;
  logic [1:0] g_mux_sel;
  logic [3:0] g_mux_in;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] sel;
    logic       bit_v;
    logic       first;
    logic       last;
    logic [3:0] word;
  } beat_t;

  beat_t sb[$];

  always #5 clk = ~clk;

  mux_sel_sequencer #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_ready(word_ready),
    .word_in(word_in), .bit_ready(bit_ready), .mux_sel(mux_sel), .mux_in(mux_in),
    .bit_valid(bit_valid), .bit_first(bit_first), .bit_last(bit_last), .busy(busy)
  );

  mux_sel_sequencer #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .word_valid(g_word_valid), .word_ready(g_word_ready),
    .word_in(g_word_in), .bit_ready(g_bit_ready), .mux_sel(g_mux_sel), .mux_in(g_mux_in),
    .bit_valid(g_bit_valid), .bit_first(g_bit_first), .bit_last(g_bit_last), .busy(g_busy)
  );

  // Downstream 4:1 mux, four equivalent codings.
  logic ter_out, case_out, ifelse_out, aor_out;
  assign ter_out = mux_sel[1] ? (mux_sel[0] ? mux_in[3] : mux_in[2])
                              : (mux_sel[0] ? mux_in[1] : mux_in[0]);
  always_comb begin
    case_out = 1'b0;
    case (mux_sel)
      2'd0: case_out = mux_in[0];
      2'd1: case_out = mux_in[1];
      2'd2: case_out = mux_in[2];
      2'd3: case_out = mux_in[3];
      default: case_out = 1'b0;
    endcase
  end
  always_comb begin
    if (mux_sel == 2'd0)      ifelse_out = mux_in[0];
    else if (mux_sel == 2'd1) ifelse_out = mux_in[1];
    else if (mux_sel == 2'd2) ifelse_out = mux_in[2];
    else                      ifelse_out = mux_in[3];
  end
  assign aor_out = (mux_in[0] & ~mux_sel[1] & ~mux_sel[0]) |
                   (mux_in[1] & ~mux_sel[1] &  mux_sel[0]) |
                   (mux_in[2] &  mux_sel[1] & ~mux_sel[0]) |
                   (mux_in[3] &  mux_sel[1] &  mux_sel[0]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input int k);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return 2'(3 - k);
`else
    return 2'(k);
`endif
  endfunction

  // Monitor: retire a beat on each valid/ready, then queue beats for a newly accepted word.
  always @(negedge clk) begin
    beat_t e;
    beat_t n;
    if (!rst && bit_valid && bit_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("beat_sel",    mux_sel,    e.sel);
        check("beat_ter",    ter_out,    e.bit_v);
        check("beat_case",   case_out,   e.bit_v);
        check("beat_ifelse", ifelse_out, e.bit_v);
        check("beat_aor",    aor_out,    e.bit_v);
        check("beat_first",  bit_first,  e.first);
        check("beat_last",   bit_last,   e.last);
        check("beat_word",   mux_in,     e.word);
      end
    end
    if (!rst && word_valid && word_ready) begin
      for (int k = 0; k < 4; k++) begin
        n.sel   = exp_sel(k);
        n.bit_v = word_in[exp_sel(k)];
        n.first = (k == 0);
        n.last  = (k == 3);
        n.word  = word_in;
        sb.push_back(n);
      end
    end
  end

  // Called at posedge+1 while the main DUT is idle; the word is taken on the next edge.
  task automatic accept_word(input logic [3:0] w);
    word_in    = w;
    word_valid = 1'b1;
    @(posedge clk);
    #1 word_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_gap;
    bit_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bit_valid, 1'b0);
    check("rst_busy",  busy,      1'b0);
    check("rst_sel",   mux_sel,   START_SEL);
    check("rst_in",    mux_in,    4'h0);
    check("rst_first", bit_first, 1'b0);
    check("rst_last",  bit_last,  1'b0);
    check("rst_ready", word_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word
    accept_word(4'b1010);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("single_idle_busy",  busy,      1'b0);
    check("single_idle_valid", bit_valid, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back with word_valid held
    word_in    = 4'hC;
    word_valid = 1'b1;
    @(posedge clk);
    #1 word_in = 4'h3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_valid", bit_valid, 1'b1);
      check("b2b_ready", word_ready, (i == 3 || i == 7));
      @(posedge clk);
      #1;
      if (i == 3) word_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    // Stall three cycles on beat 2
    accept_word(4'h6);
    repeat (2) @(posedge clk);
    #1 bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_sel",   mux_sel,   exp_sel(2));
      check("stall_in",    mux_in,    4'h6);
      check("stall_last",  bit_last,  1'b0);
      check("stall_valid", bit_valid, 1'b1);
      @(posedge clk);
    end
    #1 bit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("resume_last", bit_last, 1'b1);
    @(posedge clk);
    #1;

    // Beat order for a one-hot word
    accept_word(4'b0001);
    repeat (5) @(posedge clk);
    #1;

    // Reset in the middle of a word
    accept_word(4'h9);
    @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_valid", bit_valid, 1'b0);
    check("midrst_busy",  busy,      1'b0);
    check("midrst_sel",   mux_sel,   START_SEL);
    check("midrst_in",    mux_in,    4'h0);
    check("midrst_last",  bit_last,  1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_valid", bit_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Three-cycle gap between words on the second instance
    n_gap        = 0;
    g_word_in    = 4'hF;
    g_word_valid = 1'b1;
    @(posedge clk);
    #1 g_word_in = 4'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("gap_valid", g_bit_valid, (i < 4 || i >= 8));
      check("gap_ready", g_word_ready, (i == 7));
      if (i == 0) begin
        check("gap_in_f",  g_mux_in,    4'hF);
        check("gap_sel0",  g_mux_sel,   START_SEL);
        check("gap_first", g_bit_first, 1'b1);
      end
      if (i == 3) check("gap_last", g_bit_last, 1'b1);
      if (i == 5) check("gap_busy", g_busy, 1'b1);
      if (i == 8) check("gap_in_0", g_mux_in, 4'h0);
      if (!g_word_ready && !g_bit_valid) n_gap++;
      @(posedge clk);
      #1;
      if (i == 7) g_word_valid = 1'b0;
    end
    check("gap_cycles", n_gap, 3);

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
